// File: rtl/axis_frame_fifo_v2_0.sv
// Single-clock AXI4-Stream FIFO with optional store-and-forward frame mode.
// Frame mode releases only complete frames and drops bad or overflowing frames.
// rd_ptr advances when a beat leaves the output register. Beats held in the
// read pipeline therefore still occupy their memory slots. Capacity is exactly
// 2**ADDR_WIDTH beats, and fill_level counts every committed beat not yet consumed.
module axis_frame_fifo_v2_0 #(
    parameter int ADDR_WIDTH         = 10,
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH        = 1,
    parameter int FRAME_FIFO         = 1,
    parameter int DROP_BAD_FRAME     = 1,
    parameter int DROP_WHEN_FULL     = 1
) (
    input  logic                            s00_axis_aclk,
    input  logic                            s00_axis_aresetn,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                            s00_axis_tvalid,
    output logic                            s00_axis_tready,
    input  logic                            s00_axis_tlast,
    input  logic [TUSER_WIDTH-1:0]          s00_axis_tuser,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                            m00_axis_tvalid,
    input  logic                            m00_axis_tready,
    output logic                            m00_axis_tlast,
    output logic [TUSER_WIDTH-1:0]          m00_axis_tuser,
    output logic [ADDR_WIDTH:0]             fill_level,
    output logic                            status_overflow,
    output logic                            status_bad_frame,
    output logic                            status_good_frame
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int EW    = 1 + TUSER_WIDTH + C_AXIS_TDATA_WIDTH / 8 + C_AXIS_TDATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [EW-1:0]       mem [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;     // committed write pointer
    logic [ADDR_WIDTH:0] wr_cur_q, wr_cur_d;     // write head (includes partial frame)
    logic [ADDR_WIDTH:0] rd_ptr_q;               // consumed at the output
    logic [ADDR_WIDTH:0] rd_addr_q;              // next address to prefetch
    logic                drop_q, drop_d;
    logic                ready_q;                // low during reset, high afterwards
    logic                s1_vld_q, m_vld_q;
    logic [EW-1:0]       s1_data_q, m_data_q;
    logic                ovf_q, ovf_d, bad_q, bad_d, good_q, good_d;
    logic                full, pending, wr_acc, we, out_adv, s1_adv, rd_en, pop;

    assign full    = (wr_cur_q - rd_ptr_q) == FULL_CNT;
    assign pending = rd_addr_q != wr_ptr_q;
    assign s00_axis_tready = ready_q & (((FRAME_FIFO != 0) && (DROP_WHEN_FULL != 0)) | ~full);
    assign wr_acc  = s00_axis_tvalid & s00_axis_tready;
    assign out_adv = m00_axis_tready | ~m_vld_q;
    assign s1_adv  = out_adv | ~s1_vld_q;
    assign rd_en   = pending & s1_adv;
    assign pop     = m_vld_q & m00_axis_tready;

    assign {m00_axis_tlast, m00_axis_tuser, m00_axis_tstrb, m00_axis_tdata} = m_data_q;
    assign m00_axis_tvalid   = m_vld_q;
    assign fill_level        = wr_ptr_q - rd_ptr_q;
    assign status_overflow   = ovf_q;
    assign status_bad_frame  = bad_q;
    assign status_good_frame = good_q;

    // Write-side next state: commit, rewind on bad/overflow, drop tracking
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wr_cur_d = wr_cur_q;
        drop_d   = drop_q;
        we       = 1'b0;
        ovf_d    = 1'b0;
        bad_d    = 1'b0;
        good_d   = 1'b0;
        if (wr_acc) begin
            if (FRAME_FIFO == 0) begin
                we       = 1'b1;
                wr_cur_d = wr_cur_q + PTR_ONE;
                wr_ptr_d = wr_cur_q + PTR_ONE;
                good_d   = s00_axis_tlast;
            end else if (drop_q || full) begin
                // Throw away the partial frame; swallow beats until tlast
                wr_cur_d = wr_ptr_q;
                drop_d   = ~s00_axis_tlast;
                ovf_d    = s00_axis_tlast;
            end else begin
                we       = 1'b1;
                wr_cur_d = wr_cur_q + PTR_ONE;
                if (s00_axis_tlast) begin
                    if (s00_axis_tuser[0] && (DROP_BAD_FRAME != 0)) begin
                        wr_cur_d = wr_ptr_q;
                        bad_d    = 1'b1;
                    end else begin
                        wr_ptr_d = wr_cur_q + PTR_ONE;
                        good_d   = 1'b1;
                    end
                end
            end
        end
    end

    // Control state: pointers, drop flag, valid stages, status pulses
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            wr_ptr_q  <= '0;
            wr_cur_q  <= '0;
            rd_ptr_q  <= '0;
            rd_addr_q <= '0;
            drop_q    <= 1'b0;
            ready_q   <= 1'b0;
            s1_vld_q  <= 1'b0;
            m_vld_q   <= 1'b0;
            ovf_q     <= 1'b0;
            bad_q     <= 1'b0;
            good_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            wr_cur_q  <= wr_cur_d;
            drop_q    <= drop_d;
            ready_q   <= 1'b1;
            ovf_q     <= ovf_d;
            bad_q     <= bad_d;
            good_q    <= good_d;
            if (rd_en)   rd_addr_q <= rd_addr_q + PTR_ONE;
            if (pop)     rd_ptr_q  <= rd_ptr_q + PTR_ONE;
            if (s1_adv)  s1_vld_q  <= rd_en;
            if (out_adv) m_vld_q   <= s1_vld_q;
        end
    end

    // Storage and read datapath; data registers are deliberately not reset
    always_ff @(posedge s00_axis_aclk) begin
        if (we) mem[wr_cur_q[ADDR_WIDTH-1:0]] <=
            {s00_axis_tlast, s00_axis_tuser, s00_axis_tstrb, s00_axis_tdata};
        if (rd_en)   s1_data_q <= mem[rd_addr_q[ADDR_WIDTH-1:0]];
        if (out_adv) m_data_q  <= s1_data_q;
    end
endmodule
